// File: rtl/memory_system_pkg.sv
// Shared constants for the memory-side responder: I/O register offsets,
// FIFO status bit positions and the default I/O page base.
// No logic lives here; everything is imported by the RTL files.
package memory_system_pkg;

  localparam logic [15:0] DEFAULT_IO_BASE = 16'hFFF0;

  // Word offsets inside the 16-word I/O page
  typedef enum logic [3:0] {
    IO_LED        = 4'd0,
    IO_SW         = 4'd1,
    IO_CYCLE      = 4'd2,
    IO_TIMER_LOAD = 4'd3,
    IO_TIMER_STAT = 4'd4,
    IO_FIFO_DATA  = 4'd5,
    IO_FIFO_STAT  = 4'd6
  } io_reg_e;

  // TIMER_STAT layout
  localparam int TIMER_FLAG_BIT = 0;

  // FIFO_STAT layout
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/out_fifo.sv
// Output FIFO: circular buffer with registered pointers and occupancy count.
// Latency: a pushed word is visible at head one edge later (no pass-through).
// Backpressure: push is accepted when not full or when a pop coincides; pop ignored when empty.
module out_fifo
  import memory_system_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WORD_SIZE-1:0]          push_data,
  input  logic                          pop,
  output logic [WORD_SIZE-1:0]          head,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head reads 0 while empty so stale storage never leaks out after reset
  assign head = empty ? '0 : mem[rd_ptr];

  // Storage is not reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/memory_system.sv
// Memory-side responder: word RAM plus a 16-word I/O page (LED, switches, cycle counter, timer, output FIFO).
// Latency: reads are combinational from memory_addr; writes commit on the clk edge.
// Backpressure: output FIFO drains over out_valid/out_ready; pushes to a full FIFO without a pop are dropped and flagged.
module memory_system
  import memory_system_pkg::*;
#(
  parameter int                   WORD_SIZE     = 16,
  parameter int                   RAM_ADDR_BITS = 10,
  parameter logic [WORD_SIZE-1:0] IO_BASE       = DEFAULT_IO_BASE,
  parameter int                   FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] memory_addr,
  input  logic [WORD_SIZE-1:0] memory_out,
  input  logic                 memory_write,
  output logic [WORD_SIZE-1:0] memory_in,
  input  logic [7:0]           sw_in,
  output logic [7:0]           led_out,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_SIZE-1:0] ram [2**RAM_ADDR_BITS];
  logic                 in_ram, in_io, io_wr;
  logic [3:0]           io_off;
  logic                 wr_led, wr_cycle, wr_tload, wr_tstat, wr_fdata, wr_fstat;
  logic [7:0]           sw_meta, sw_sync;
  logic [WORD_SIZE-1:0] cycle_cnt;
  logic [WORD_SIZE-1:0] timer_load, timer_count;
  logic                 timer_flag, timer_expire;
  logic                 overflow, pop_fire;
  logic [WORD_SIZE-1:0] fifo_head, fifo_stat;
  logic                 fifo_empty, fifo_full;
  logic [CW-1:0]        fifo_count;

  assign in_ram   = (memory_addr[WORD_SIZE-1:RAM_ADDR_BITS] == '0);
  assign in_io    = (memory_addr[WORD_SIZE-1:4] == IO_BASE[WORD_SIZE-1:4]);
  assign io_off   = memory_addr[3:0];
  assign io_wr    = memory_write && in_io;
  assign wr_led   = io_wr && (io_off == IO_LED);
  assign wr_cycle = io_wr && (io_off == IO_CYCLE);
  assign wr_tload = io_wr && (io_off == IO_TIMER_LOAD);
  assign wr_tstat = io_wr && (io_off == IO_TIMER_STAT);
  assign wr_fdata = io_wr && (io_off == IO_FIFO_DATA);
  assign wr_fstat = io_wr && (io_off == IO_FIFO_STAT);

  assign timer_expire = (timer_load != '0) && (timer_count == WORD_SIZE'(1));
  assign pop_fire     = out_valid && out_ready;
  assign out_valid    = !fifo_empty;
  assign out_data     = fifo_head;

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (memory_write && in_ram) ram[memory_addr[RAM_ADDR_BITS-1:0]] <= memory_out;
  end

  // LED register and two-flop switch synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      if (wr_led) led_out <= memory_out[7:0];
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  // Free-running cycle counter; a write zeroes it instead of incrementing
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cycle_cnt <= '0;
    else if (wr_cycle) cycle_cnt <= '0;
    else               cycle_cnt <= cycle_cnt + 1'b1;
  end

  // Reload timer: write loads both, expiry reloads, otherwise count down while enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_load  <= '0;
      timer_count <= '0;
    end else if (wr_tload) begin
      timer_load  <= memory_out;
      timer_count <= memory_out;
    end else if (timer_expire) begin
      timer_count <= timer_load;
    end else if (timer_load != '0) begin
      timer_count <= timer_count - 1'b1;
    end
  end

  // Timer flag: expiry sets it unless a load write lands on the same edge; set beats clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         timer_flag <= 1'b0;
    else if (timer_expire && !wr_tload)              timer_flag <= 1'b1;
    else if (wr_tstat && memory_out[TIMER_FLAG_BIT]) timer_flag <= 1'b0;
  end

  // Sticky overflow: a push to a full FIFO that is not being drained this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     overflow <= 1'b0;
    else if (wr_fdata && fifo_full && !pop_fire) overflow <= 1'b1;
    else if (wr_fstat && memory_out[STAT_OVF_BIT]) overflow <= 1'b0;
  end

  out_fifo #(
    .WORD_SIZE  (WORD_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_fdata),
    .push_data (memory_out),
    .pop       (pop_fire),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // FIFO status word assembly
  always_comb begin
    fifo_stat                          = '0;
    fifo_stat[STAT_EMPTY_BIT]          = fifo_empty;
    fifo_stat[STAT_FULL_BIT]           = fifo_full;
    fifo_stat[STAT_OVF_BIT]            = overflow;
    fifo_stat[STAT_COUNT_LSB +: CW]    = fifo_count;
  end

  // Zero-latency, side-effect-free read mux; unmapped space reads 0
  always_comb begin
    memory_in = '0;
    if (in_io) begin
      case (io_off)
        IO_LED:        memory_in = WORD_SIZE'(led_out);
        IO_SW:         memory_in = WORD_SIZE'(sw_sync);
        IO_CYCLE:      memory_in = cycle_cnt;
        IO_TIMER_LOAD: memory_in = timer_load;
        IO_TIMER_STAT: memory_in = WORD_SIZE'(timer_flag);
        IO_FIFO_STAT:  memory_in = fifo_stat;
        default:       memory_in = '0;
      endcase
    end else if (in_ram) begin
      memory_in = ram[memory_addr[RAM_ADDR_BITS-1:0]];
    end
  end

endmodule
